// File: rtl/seq_fsm_hamming_secded.sv
// Sequence-recognition Moore FSM whose state register is SEC-DED protected,
// scrubbed on every edge, with saturating SEC/DED counters.
// Ports: clk_i, rst_i (sync, active-high), valid_i, data_i, inject_i,
//   cnt_clr_i; state_o, done_o, seq_id_o, error_o, sec_o, ded_o,
//   sec_cnt_o, ded_cnt_o.
module seq_fsm_hamming_secded #(
  parameter int IO_SIZE_G = 3,
  parameter int N_SEQ_G = 2,
  parameter int SEQ_LEN_G = 3,
  parameter logic [N_SEQ_G*SEQ_LEN_G*IO_SIZE_G-1:0] SEQ_TABLE_G = 18'o654321,
  parameter logic [IO_SIZE_G-1:0] IDLE_SYM_G = '0,
  parameter int CNT_WIDTH_G = 8,
  localparam int NSTATE = 2 + N_SEQ_G * SEQ_LEN_G,
  localparam int STATE_W = $clog2(NSTATE),
  localparam int P = (STATE_W <= 1) ? 2 :
                     (STATE_W <= 4) ? 3 :
                     (STATE_W <= 11) ? 4 :
                     (STATE_W <= 26) ? 5 :
                     (STATE_W <= 57) ? 6 : 7,
  localparam int ENC_W = STATE_W + P + 1,
  localparam int SID_W = (N_SEQ_G > 1) ? $clog2(N_SEQ_G) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [IO_SIZE_G-1:0]   data_i,
  input  logic [ENC_W-1:0]       inject_i,
  input  logic                   cnt_clr_i,
  output logic [STATE_W-1:0]     state_o,
  output logic                   done_o,
  output logic [SID_W-1:0]       seq_id_o,
  output logic                   error_o,
  output logic                   sec_o,
  output logic                   ded_o,
  output logic [CNT_WIDTH_G-1:0] sec_cnt_o,
  output logic [CNT_WIDTH_G-1:0] ded_cnt_o
);

  localparam logic [STATE_W-1:0] S_IDLE = '0;
  localparam logic [STATE_W-1:0] S_ERR = STATE_W'(1);

  // Bit 0 is overall parity; bits 1.. follow Hamming positions with
  // check bits at powers of two and data bits filling the rest in order.
  function automatic logic [ENC_W-1:0] encode(
    input logic [STATE_W-1:0] d
  );
    logic [ENC_W-1:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p < ENC_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[k];
        k++;
      end
    end
    for (int b = 0; b < P; b++) begin
      for (int p = 1; p < ENC_W; p++) begin
        if (((p >> b) & 1) == 1 && p != (1 << b))
          c[1 << b] = c[1 << b] ^ c[p];
      end
    end
    c[0] = ^c[ENC_W-1:1];
    return c;
  endfunction

  function automatic logic [IO_SIZE_G-1:0] sym(input int s, input int j);
    return SEQ_TABLE_G[(s * SEQ_LEN_G + j) * IO_SIZE_G +: IO_SIZE_G];
  endfunction

  logic [ENC_W-1:0]   enc_q;
  logic [ENC_W-1:0]   fix;
  logic [P-1:0]       syn;
  logic               par_bad;
  logic [STATE_W-1:0] idx;
  logic [STATE_W-1:0] nxt;

  always_comb begin
    int k;
    syn = '0;
    for (int p = 1; p < ENC_W; p++) begin
      if (enc_q[p]) syn = syn ^ P'(p);
    end
    par_bad = ^enc_q;
    sec_o = (syn != '0) && par_bad;
    ded_o = (syn != '0) && !par_bad;
    fix = enc_q;
    if (sec_o && int'(syn) < ENC_W) fix[syn] = ~fix[syn];
    idx = '0;
    k = 0;
    for (int p = 1; p < ENC_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        idx[k] = fix[p];
        k++;
      end
    end
  end

  always_comb begin
    nxt = idx;
    if (idx == S_IDLE) begin
      if (valid_i) begin
        for (int s = 0; s < N_SEQ_G; s++) begin
          if (data_i == sym(s, 0))
            nxt = STATE_W'(2 + s * SEQ_LEN_G);
        end
      end
    end else if (idx == S_ERR) begin
      nxt = S_IDLE;
    end else if (valid_i) begin
      for (int s = 0; s < N_SEQ_G; s++) begin
        for (int j = 0; j < SEQ_LEN_G - 1; j++) begin
          if (int'(idx) == 2 + s * SEQ_LEN_G + j)
            nxt = (data_i == sym(s, j + 1)) ? idx + 1'b1 : S_ERR;
        end
        if (int'(idx) == 1 + (s + 1) * SEQ_LEN_G) begin
          nxt = (data_i == IDLE_SYM_G) ? S_IDLE : S_ERR;
          for (int t = 0; t < N_SEQ_G; t++) begin
            if (data_i == sym(t, 0))
              nxt = STATE_W'(2 + t * SEQ_LEN_G);
          end
        end
      end
    end
    // Uncorrectable or out-of-range states are forced out through ERROR.
    if (ded_o || int'(idx) >= NSTATE) nxt = S_ERR;
  end

  always_comb begin
    state_o = idx;
    error_o = (idx == S_ERR);
    done_o = 1'b0;
    seq_id_o = '0;
    for (int s = 0; s < N_SEQ_G; s++) begin
      if (int'(idx) >= 2 + s * SEQ_LEN_G &&
          int'(idx) < 2 + (s + 1) * SEQ_LEN_G)
        seq_id_o = SID_W'(s);
      if (int'(idx) == 1 + (s + 1) * SEQ_LEN_G)
        done_o = 1'b1;
    end
  end

  // Rewriting the encoded next state every edge scrubs single-bit upsets.
  always_ff @(posedge clk_i) begin
    if (rst_i) enc_q <= encode(S_IDLE);
    else enc_q <= encode(nxt) ^ inject_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      sec_cnt_o <= '0;
      ded_cnt_o <= '0;
    end else begin
      if (sec_o && !(&sec_cnt_o)) sec_cnt_o <= sec_cnt_o + 1'b1;
      if (ded_o && !(&ded_cnt_o)) ded_cnt_o <= ded_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_fsm_hamming_secded.sv
// Directed table-driven bench for seq_fsm_hamming_secded (default params).
// Checks sequences, errors, SEC scrub/saturation, DED, clear and reset.
module tb_seq_fsm_hamming_secded;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [2:0] data;
  logic [6:0] inject;
  logic       cnt_clr;
  logic [2:0] state;
  logic       done;
  logic [0:0] seq_id;
  logic       error;
  logic       sec;
  logic       ded;
  logic [7:0] sec_cnt;
  logic [7:0] ded_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_fsm_hamming_secded dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data),
    .inject_i(inject), .cnt_clr_i(cnt_clr),
    .state_o(state), .done_o(done), .seq_id_o(seq_id),
    .error_o(error), .sec_o(sec), .ded_o(ded),
    .sec_cnt_o(sec_cnt), .ded_cnt_o(ded_cnt)
  );

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [2:0] data;
    logic [6:0] inj;
    logic       clr;
    logic [2:0] e_state;
    logic       e_done;
    logic       e_seq;
    logic       e_err;
    logic       e_sec;
    logic       e_ded;
    logic [7:0] e_scnt;
    logic [7:0] e_dcnt;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic v, input logic [2:0] d,
    input logic [6:0] i, input logic c, input logic [2:0] st,
    input logic dn, input logic sq, input logic er,
    input logic sc, input logic dd,
    input logic [7:0] scn, input logic [7:0] dcn
  );
    return '{r, v, d, i, c, st, dn, sq, er, sc, dd, scn, dcn};
  endfunction

  function automatic logic [23:0] outs();
    return {state, done, seq_id, error, sec, ded, sec_cnt, ded_cnt};
  endfunction

  task automatic check(input string name,
                       input logic [23:0] act,
                       input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [2:0] d,
                       input logic [6:0] i, input logic c);
    rst = r;
    valid = v;
    data = d;
    inject = i;
    cnt_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input string tag, input int n, input vec_t t);
    drive(t.rst, t.valid, t.data, t.inj, t.clr);
    check($sformatf("%s[%0d]", tag, n), outs(),
          {t.e_state, t.e_done, t.e_seq, t.e_err, t.e_sec, t.e_ded,
           t.e_scnt, t.e_dcnt});
  endtask

  vec_t t1[$];
  vec_t t2[$];

  initial begin
    rst = 1'b1;
    valid = 1'b0;
    data = '0;
    inject = '0;
    cnt_clr = 1'b0;

    //           rst v  d     inj   clr st dn sq er sc dd scnt dcnt
    t1.push_back(mk(1, 0, 3'd0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 1, 3'd1, 7'h00, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 1, 3'd2, 7'h00, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 1, 3'd3, 7'h00, 0, 4, 1, 0, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 1, 3'd0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 1, 3'd4, 7'h00, 0, 5, 0, 1, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 1, 3'd5, 7'h00, 0, 6, 0, 1, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 1, 3'd6, 7'h00, 0, 7, 1, 1, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 1, 3'd1, 7'h00, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 1, 3'd2, 7'h00, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 1, 3'd3, 7'h00, 0, 4, 1, 0, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 1, 3'd0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 1, 3'd1, 7'h00, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 1, 3'd5, 7'h00, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    t1.push_back(mk(0, 0, 3'd0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 1, 3'd1, 7'h00, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 0, 3'd7, 7'h00, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 1, 3'd2, 7'h00, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    t1.push_back(mk(0, 0, 3'd0, 7'h04, 0, 3, 0, 0, 0, 1, 0, 0, 0));
    t1.push_back(mk(0, 0, 3'd0, 7'h00, 0, 3, 0, 0, 0, 0, 0, 1, 0));

    // Continues from state 3 with sec_cnt saturated at 255.
    t2.push_back(mk(0, 1, 3'd3, 7'h00, 0, 4, 1, 0, 0, 0, 0, 255, 0));
    t2.push_back(mk(0, 1, 3'd4, 7'h00, 0, 5, 0, 1, 0, 0, 0, 255, 0));
    t2.push_back(mk(0, 1, 3'd5, 7'h00, 0, 6, 0, 1, 0, 0, 0, 255, 0));
    t2.push_back(mk(0, 0, 3'd0, 7'h03, 0, 6, 0, 1, 0, 0, 1, 255, 0));
    t2.push_back(mk(0, 0, 3'd0, 7'h00, 0, 1, 0, 0, 1, 0, 0, 255, 1));
    t2.push_back(mk(0, 0, 3'd0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 255, 1));
    t2.push_back(mk(0, 0, 3'd0, 7'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    t2.push_back(mk(0, 0, 3'd0, 7'h04, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    t2.push_back(mk(1, 0, 3'd0, 7'h7f, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t2.push_back(mk(0, 1, 3'd1, 7'h00, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    t2.push_back(mk(1, 1, 3'd2, 7'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t2.push_back(mk(0, 1, 3'd2, 7'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int n = 0; n < t1.size(); n++) apply("seq", n, t1[n]);

    // 300 single-bit upsets while holding in state 3.
    for (int n = 0; n < 300; n++) begin
      drive(0, 0, 3'd0, 7'h04, 0);
      drive(0, 0, 3'd0, 7'h00, 0);
    end
    check("sec_saturate", outs(),
          {3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255, 8'd0});

    for (int n = 0; n < t2.size(); n++) apply("fault", n, t2[n]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
